serializer: RTL and testbench
=============================

Name: serializer

Overview:
- Parallel-to-serial stage that sits directly upstream of the 1-bit deserializer.
- Accepts a DATA_W-bit word plus a bit-count modifier.
- Shifts out only the requested number of bits, MSB first, one bit per clock, with a per-bit valid strobe.
- MSB-first order matches the downstream deserializer, which fills its word from the top index down; ser_data_o/ser_data_val_o connect directly to its data_i/data_val_i.

Parameters:
- DATA_W, 16, width of parallel input word; power of two, >= 4.
- MOD_W, $clog2(DATA_W), width of the bit-count modifier (localparam-style, not overridden by users).

Ports:
- clk_i  input  1  single clock; all logic on posedge.
- arst_i  input  1  asynchronous, active-high reset.
- data_i  input  DATA_W  parallel word; bit DATA_W-1 is sent first.
- data_mod_i  input  MOD_W  number of bits to send; 0 means all DATA_W bits.
- data_val_i  input  1  request strobe; qualifies data_i/data_mod_i for one cycle.
- ser_data_o  output  1  serial bit.
- ser_data_val_o  output  1  ser_data_o carries a valid bit this cycle.
- busy_o  output  1  block is transmitting; new requests are ignored.

Behaviour:
- Reset (async assert, released synchronously by the integrating design):
  - state=IDLE; ser_data_o=0, ser_data_val_o=0, busy_o=0.
  - Internal shift register and counter cleared.
  - Reset mid-word aborts transmission immediately; no further bits are emitted.
- Acceptance: a request is accepted on a rising edge where data_val_i=1 and busy_o=0 and the effective length is valid.
- Effective length: L = DATA_W if data_mod_i==0, else data_mod_i.
  - data_mod_i==1 or 2 is illegal: the request is silently dropped, busy_o stays 0, nothing is emitted.
  - All other values (3..DATA_W-1, 0) are legal.
- Latency: for a request accepted at edge N, the first bit (data_i[DATA_W-1]) appears on ser_data_o with ser_data_val_o=1 in the cycle after edge N.
  - Bits k=0..L-1 follow on consecutive cycles; bit k = data_i[DATA_W-1-k].
  - Bits below DATA_W-L are never sent.
- busy_o: high in exactly the cycles where ser_data_val_o=1 (plus the parity cycle when enabled).
  - busy_o is low in the cycle after the last bit.
  - The earliest next acceptance is the edge that ends the last-bit cycle's successor, i.e. there is exactly one idle cycle between words.
- data_val_i while busy_o=1 is ignored; captured data is not modified.
- Idle outputs: ser_data_o=0 whenever ser_data_val_o=0.
- State machine:
  - IDLE -> SHIFT on valid acceptance.
  - SHIFT -> IDLE when the bit counter reaches its last bit (SHIFT -> PARITY if the feature is enabled).
  - PARITY -> IDLE after one cycle.
- Counter: MOD_W+1 bits wide, loaded with L-1 on acceptance, decrements each SHIFT cycle, last bit when it equals 0. No wrap-around is reachable.
- Shift register: loaded with data_i on acceptance, shifted left each SHIFT cycle, ser_data_o driven from its MSB (registered output).
- Inputs are sampled only at the acceptance edge; later changes to data_i/data_mod_i have no effect.

Optional Feature:
- Macro: SERIALIZER_PARITY_EN.
- Defined:
  - After the L data bits, one extra cycle in state PARITY drives ser_data_o = XOR of the L transmitted bits (even parity) with ser_data_val_o=1 and busy_o=1.
  - Total serial length is L+1.
  - A parity accumulator register is cleared on acceptance and on reset.
- Undefined: the PARITY state and accumulator are not built; serial length is L.

Test Plan:
- Reset, data_val_i=1, data_i=16'hA5C3, data_mod_i=0 -> 16 valid cycles starting the cycle after acceptance, bits 1010_0101_1100_0011 in order; busy_o high for those 16 cycles; idle afterwards. Through the deserializer, deser_data_o=16'hA5C3.
- data_i=16'hF000, data_mod_i=5 -> exactly 5 valid bits 1,1,1,1,0, then busy_o=0. data_mod_i=3 -> 3 bits 1,1,1.
- data_mod_i=1 and data_mod_i=2 with data_val_i=1 -> no ser_data_val_o and busy_o stays 0 for 20 cycles.
- Accept 16'hFFFF/mod 0, then pulse data_val_i with 16'h0000 during bits 3..10 -> output is still 16 ones; a request on the first cycle with busy_o=0 is accepted and sends 16 zeros.
- Assert arst_i asynchronously during bit 7 of a 16-bit word -> ser_data_val_o, busy_o, ser_data_o go to 0 without waiting for a clock edge. After release, a new 4-bit request 16'h9000/mod 4 sends 1,0,0,1 cleanly.
- With SERIALIZER_PARITY_EN: 16'hA5C3/mod 0 (eight ones) -> 17th valid bit = 0; 16'hE000/mod 3 -> bits 1,1,1 then parity 1; busy_o covers 17 and 4 cycles respectively.

Source files
------------

// File: rtl/serializer.sv
// -----------------------------------------------------------------------------
// serializer
//
// Parallel-to-serial stage feeding a 1-bit deserializer. A DATA_W-bit word is
// accepted together with a bit-count modifier. Only the top L bits are shifted
// out, MSB first, one bit per clock, each with a valid strobe.
//
//   L = DATA_W when data_mod_i == 0, otherwise L = data_mod_i.
//   data_mod_i of 1 or 2 is illegal, and such a request is dropped silently.
//
// The first bit appears in the cycle after the acceptance edge. busy_o follows
// the valid strobe exactly. There is one idle cycle between consecutive words.
//
// Optional build macro: SERIALIZER_PARITY_EN
//   When this macro is defined, one extra PARITY cycle follows the data bits.
//   In that cycle ser_data_o carries the even parity (XOR) of the L bits that
//   were sent. When the macro is undefined, the PARITY state and the
//   accumulator are not built.
// -----------------------------------------------------------------------------
module serializer #(
  parameter  int DATA_W = 16,
  localparam int MOD_W  = $clog2(DATA_W)
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [MOD_W-1:0]  data_mod_i,
  input  logic              data_val_i,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  output logic              busy_o
);

  // The length and counter width is one bit wider than the modifier, so that
  // the value DATA_W itself can be represented.
  localparam int             LEN_W    = MOD_W + 1;
  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(DATA_W);
  localparam logic [LEN_W-1:0] MIN_LEN  = LEN_W'(3);
  localparam logic [LEN_W-1:0] ONE      = LEN_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

  state_t             state_q;
  logic [DATA_W-1:0]  shift_q;
  logic [LEN_W-1:0]   cnt_q;
  logic               ser_data_q;
  logic               ser_val_q;
  logic               busy_q;
`ifdef SERIALIZER_PARITY_EN
  logic               parity_q;
`endif

  // Request decode: effective length, legality, and the counter start value.
  logic [LEN_W-1:0]   req_len;
  logic [LEN_W-1:0]   req_cnt_d;
  logic               req_legal;
  logic               accept;
  logic [DATA_W-1:0]  shift_next;

  // Decode the incoming request and pre-compute the next shift value.
  always_comb begin
    // NOTE: every always_comb output gets a default value first. A path that
    // leaves a signal unassigned would infer a latch.
    req_len    = {1'b0, data_mod_i};
    req_cnt_d  = '0;
    req_legal  = 1'b0;
    accept     = 1'b0;
    shift_next = shift_q << 1;

    if (data_mod_i == '0) begin
      req_len = FULL_LEN;
    end
    req_legal = (req_len >= MIN_LEN);
    req_cnt_d = req_len - ONE;
    accept    = data_val_i && !busy_q && req_legal;
  end

  // Control FSM. All outputs are registered in this block.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      // NOTE: the shift register is reset along with the control state. Clearing
      // it costs little, and it keeps the datapath free of X values after reset.
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      ser_data_q <= 1'b0;
      ser_val_q  <= 1'b0;
      busy_q     <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments. Every register
      // then updates from the values it had before the edge.
      case (state_q)
        ST_IDLE: begin
          ser_data_q <= 1'b0;
          ser_val_q  <= 1'b0;
          busy_q     <= 1'b0;
          if (accept) begin
            // Bit 0 goes straight to the output register. The counter holds
            // the number of bits still to follow.
            state_q    <= ST_SHIFT;
            shift_q    <= data_i;
            cnt_q      <= req_cnt_d;
            ser_data_q <= data_i[DATA_W-1];
            ser_val_q  <= 1'b1;
            busy_q     <= 1'b1;
`ifdef SERIALIZER_PARITY_EN
            parity_q   <= 1'b0;
`endif
          end
        end

        ST_SHIFT: begin
`ifdef SERIALIZER_PARITY_EN
          // Fold the bit now on the wire into the running parity.
          parity_q <= parity_q ^ ser_data_q;
`endif
          if (cnt_q == '0) begin
            // The output register holds the last data bit.
`ifdef SERIALIZER_PARITY_EN
            state_q    <= ST_PARITY;
            ser_data_q <= parity_q ^ ser_data_q;
            ser_val_q  <= 1'b1;
            busy_q     <= 1'b1;
`else
            state_q    <= ST_IDLE;
            ser_data_q <= 1'b0;
            ser_val_q  <= 1'b0;
            busy_q     <= 1'b0;
`endif
          end else begin
            shift_q    <= shift_next;
            ser_data_q <= shift_next[DATA_W-1];
            cnt_q      <= cnt_q - ONE;
          end
        end

`ifdef SERIALIZER_PARITY_EN
        ST_PARITY: begin
          state_q    <= ST_IDLE;
          ser_data_q <= 1'b0;
          ser_val_q  <= 1'b0;
          busy_q     <= 1'b0;
        end
`endif

        default: begin
          state_q    <= ST_IDLE;
          ser_data_q <= 1'b0;
          ser_val_q  <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign ser_data_o     = ser_data_q;
  assign ser_data_val_o = ser_val_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_serializer.sv
// -----------------------------------------------------------------------------
// tb_serializer
//
// Self-checking bench for serializer (DATA_W = 16). It uses a table of directed
// vectors, hand-written sequences for the busy-ignore and async-reset cases,
// and randomized requests. Each request's cycle-by-cycle trace is compared
// against a reference stream that the bench builds from the length and bit
// rules. Define SERIALIZER_PARITY_EN for both the bench and the RTL to cover
// the parity build.
// -----------------------------------------------------------------------------
module tb_serializer;

  localparam int DW  = 16;
  localparam int WIN = 20;
`ifdef SERIALIZER_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic        clk;
  logic        arst;
  logic [15:0] data;
  logic [3:0]  mod;
  logic        dval;
  logic        sdat;
  logic        sval;
  logic        busy;

  int total = 0;
  int bad   = 0;

  serializer #(.DATA_W(DW)) dut (
    .clk_i          (clk),
    .arst_i         (arst),
    .data_i         (data),
    .data_mod_i     (mod),
    .data_val_i     (dval),
    .ser_data_o     (sdat),
    .ser_data_val_o (sval),
    .busy_o         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // Reference stream. It is sampled at negedges; index 0 is the drive cycle,
  // and bit k of the word appears at index k+1.
  function automatic void model(input logic [15:0] d, input logic [3:0] m,
                                output logic [63:0] ev, output logic [63:0] ed);
    int  len;
    logic p;
    ev  = '0;
    ed  = '0;
    p   = 1'b0;
    len = (m == 4'd0) ? 16 : int'(m);
    if (len < 3) return;
    for (int k = 0; k < len; k++) begin
      ev[k+1] = 1'b1;
      ed[k+1] = d[15-k];
      p       = p ^ d[15-k];
    end
    if (P == 1) begin
      ev[len+1] = 1'b1;
      ed[len+1] = p;
    end
  endfunction

  // Drive one request and watch a WIN-cycle trace. After the drive cycle the
  // data and modifier inputs carry junk, which must have no effect.
  task automatic run_req(input logic [15:0] d, input logic [3:0] m,
                         input int exp_nbits, input logic [15:0] exp_word,
                         input string name);
    logic [63:0] gv, gd, gb, ev, ed;
    logic [15:0] word;
    int nv;
    gv = '0; gd = '0; gb = '0;
    for (int k = 0; k < WIN; k++) begin
      @(negedge clk);
      gv[k] = sval;
      gd[k] = sdat;
      gb[k] = busy;
      if (k == 0) begin
        dval = 1'b1; data = d; mod = m;
      end else begin
        dval = 1'b0; data = 16'($urandom); mod = 4'($urandom);
      end
    end
    model(d, m, ev, ed);
    check({name, "_val"},  gv, ev);
    check({name, "_dat"},  gd, ed);
    check({name, "_busy"}, gb, ev);
    check({name, "_cnt"},  64'($countones(gv)), 64'(exp_nbits + ((exp_nbits > 0) ? P : 0)));
    // Rebuild the word the way the deserializer would, filling from the top down.
    word = '0;
    nv   = 0;
    for (int k = 0; k < WIN; k++) begin
      if (gv[k] && nv < exp_nbits) begin
        word[15-nv] = gd[k];
        nv++;
      end
    end
    check({name, "_word"}, 64'(word), 64'(exp_word));
  endtask

  typedef struct {
    logic [15:0] d;
    logic [3:0]  m;
    int          nbits;
    logic [15:0] word;
    string       name;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [63:0] gv, gd, gb, ev, ed;
    logic [15:0] rd, ones16, rw;
    logic [3:0]  rm;
    int          rl, n1;

    vecs[0] = '{16'hA5C3, 4'd0,  16, 16'hA5C3, "a5c3_full"};
    vecs[1] = '{16'hF000, 4'd5,   5, 16'hF000, "f000_m5"};
    vecs[2] = '{16'hF000, 4'd3,   3, 16'hE000, "f000_m3"};
    vecs[3] = '{16'hBEEF, 4'd1,   0, 16'h0000, "illegal_m1"};
    vecs[4] = '{16'hBEEF, 4'd2,   0, 16'h0000, "illegal_m2"};
    vecs[5] = '{16'h9000, 4'd4,   4, 16'h9000, "9000_m4"};
    vecs[6] = '{16'h8001, 4'd0,  16, 16'h8001, "8001_full"};
    vecs[7] = '{16'h7FFF, 4'd15, 15, 16'h7FFE, "7fff_m15"};

    arst = 1'b1; dval = 1'b0; data = '0; mod = '0;
    #12;
    check("rst_val",  64'(sval), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_dat",  64'(sdat), 64'(0));
    @(negedge clk);
    arst = 1'b0;

    // Directed table
    for (int i = 0; i < 8; i++)
      run_req(vecs[i].d, vecs[i].m, vecs[i].nbits, vecs[i].word, vecs[i].name);

    // Busy-ignore: a 16'hFFFF word, 16'h0000 pulses during bits 3..10, then a
    // request on the first idle cycle.
    n1 = 16 + P;
    gv = '0; gd = '0; gb = '0; ev = '0; ed = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      gv[k] = sval; gd[k] = sdat; gb[k] = busy;
      dval = (k == 0) || (k >= 4 && k <= 11) || (k == n1 + 1);
      data = (k == 0) ? 16'hFFFF : 16'h0000;
      mod  = 4'd0;
    end
    dval = 1'b0;
    for (int k = 1; k <= n1; k++) ev[k] = 1'b1;
    for (int k = n1 + 2; k <= 2*n1 + 1; k++) ev[k] = 1'b1;
    for (int k = 1; k <= 16; k++) ed[k] = 1'b1;
    check("ign_val",  gv, ev);
    check("ign_dat",  gd, ed);
    check("ign_busy", gb, ev);

    // Async reset during bit 7 of a 16-bit word
    @(negedge clk);
    dval = 1'b1; data = 16'hFFFF; mod = 4'd0;
    @(negedge clk);
    dval = 1'b0;
    for (int k = 2; k <= 8; k++) @(negedge clk);
    check("arst_pre_val", 64'(sval), 64'(1));
    #2 arst = 1'b1;
    #1;
    check("arst_val",  64'(sval), 64'(0));
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_dat",  64'(sdat), 64'(0));
    @(negedge clk);
    @(negedge clk);
    check("arst_hold_val", 64'(sval), 64'(0));
    arst = 1'b0;
    run_req(16'h9000, 4'd4, 4, 16'h9000, "post_rst_9000");

    // Randomized requests
    ones16 = 16'hFFFF;
    for (int i = 0; i < 40; i++) begin
      rd = 16'($urandom);
      rm = 4'($urandom_range(0, 15));
      rl = (rm == 4'd0) ? 16 : int'(rm);
      if (rl < 3) begin
        rl = 0;
        rw = 16'h0000;
      end else begin
        rw = rd & (ones16 << (16 - rl));
      end
      run_req(rd, rm, rl, rw, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
